// File: rtl/design1_pkg.sv
// Shared types and constants for the DRL accelerator control shell:
// FSM states, config word map and field offsets/widths.
package design1_pkg;

  localparam int RD_BEATS_DEF    = 16;
  localparam int CALC_CYCLES_DEF = 8;

  localparam int NUM_CFG = 4;
  localparam int CFG_DW  = 16;
  localparam int MOVE_W  = 7;
  localparam int WRC_W   = 12;

  localparam logic [1:0] CFG_W0 = 2'd0;
  localparam logic [1:0] CFG_W1 = 2'd1;
  localparam logic [1:0] CFG_W2 = 2'd2;
  localparam logic [1:0] CFG_W3 = 2'd3;

  // word0
  localparam int MODE_LSB  = 14, MODE_W  = 2;
  localparam int POOL_LSB  = 12, POOL_W  = 2;
  localparam int RELU_LSB  = 11;
  localparam int STRD_LSB  = 8,  STRD_W  = 3;
  localparam int PSUM_LSB  = 4,  PSUM_W  = 4;
  // word1
  localparam int ZMOV_LSB  = 9,  ZMOV_W  = 7;
  localparam int YMOV_LSB  = 2,  YMOV_W  = 7;
  // word2
  localparam int IMGB_LSB  = 11, BASE_W  = 5;
  localparam int WGTB_LSB  = 6;
  localparam int XMOV_LSB  = 0,  XMOV_W  = 6;
  // word3
  localparam int WRB_LSB   = 12, WRB_W   = 4;
  localparam int WRC_LSB   = 0;

  typedef enum logic [2:0] {IDLE, RD, CALC, WR, DONE} state_e;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [POOL_W-1:0] pool;
    logic              relu;
    logic [STRD_W-1:0] stride;
    logic [PSUM_W-1:0] psum_shift;
    logic [BASE_W-1:0] img_base;
    logic [BASE_W-1:0] wgt_base;
    logic [WRB_W-1:0]  wr_base;
  } dp_cfg_t;

  typedef struct packed {
    dp_cfg_t           dp;
    logic [MOVE_W-1:0] xmove;
    logic [MOVE_W-1:0] ymove;
    logic [MOVE_W-1:0] zmove;
    logic [WRC_W-1:0]  wr_count;
  } cfg_fields_t;

  // A move count of zero still runs one pass along that axis.
  function automatic logic [MOVE_W-1:0] move_norm(input logic [MOVE_W-1:0] m);
    return (m == '0) ? MOVE_W'(1) : m;
  endfunction

endpackage

// File: rtl/design1_if.sv
// Host-side bus of the control shell: config writes, job start, DMA read
// handshake, completion pulse and the snapshotted datapath config.
interface design1_if;
  import design1_pkg::*;

  logic [15:0] i_cfg;
  logic [1:0]  i_cfg_addr;
  logic        i_cfg_wr_en;
  logic        i_start;
  logic        i_dma_rd_ready;
  logic        o_finish;
  dp_cfg_t     dp_cfg;

  modport master (
    output i_cfg, i_cfg_addr, i_cfg_wr_en, i_start, i_dma_rd_ready,
    input  o_finish, dp_cfg
  );

  modport slave (
    input  i_cfg, i_cfg_addr, i_cfg_wr_en, i_start, i_dma_rd_ready,
    output o_finish, dp_cfg
  );
endinterface

// File: rtl/design1_cfg_regs.sv
// 4x16 config register file with write decode; unpacks the words into
// named fields for the control FSM and datapath.
module design1_cfg_regs
  import design1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output cfg_fields_t fields
);

  logic [NUM_CFG-1:0][CFG_DW-1:0] cfg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cfg_q       <= '0;
    else if (wr_en) cfg_q[addr] <= wdata;
  end

  // Reserved bits are storage only; nothing downstream looks at them.
  always_comb begin
    fields               = '0;
    fields.dp.mode       = cfg_q[CFG_W0][MODE_LSB +: MODE_W];
    fields.dp.pool       = cfg_q[CFG_W0][POOL_LSB +: POOL_W];
    fields.dp.relu       = cfg_q[CFG_W0][RELU_LSB];
    fields.dp.stride     = cfg_q[CFG_W0][STRD_LSB +: STRD_W];
    fields.dp.psum_shift = cfg_q[CFG_W0][PSUM_LSB +: PSUM_W];
    fields.zmove         = cfg_q[CFG_W1][ZMOV_LSB +: ZMOV_W];
    fields.ymove         = cfg_q[CFG_W1][YMOV_LSB +: YMOV_W];
    fields.dp.img_base   = cfg_q[CFG_W2][IMGB_LSB +: BASE_W];
    fields.dp.wgt_base   = cfg_q[CFG_W2][WGTB_LSB +: BASE_W];
    fields.xmove         = MOVE_W'(cfg_q[CFG_W2][XMOV_LSB +: XMOV_W]);
    fields.dp.wr_base    = cfg_q[CFG_W3][WRB_LSB +: WRB_W];
    fields.wr_count      = cfg_q[CFG_W3][WRC_LSB +: WRC_W];
  end

endmodule

// File: rtl/design1_wrapper.sv
// Control shell of the DRL accelerator: tiled RD/CALC loop then write-back.
// Optional CFG_LOCK_EN: config writes are dropped while a job is running.
module design1_wrapper
  import design1_pkg::*;
#(
  parameter int RD_BEATS    = RD_BEATS_DEF,
  parameter int CALC_CYCLES = CALC_CYCLES_DEF
) (
  input logic      i_clk,
  input logic      i_rst,
  design1_if.slave bus
);

  localparam int BW = (RD_BEATS    > 1) ? $clog2(RD_BEATS)    : 1;
  localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(RD_BEATS - 1);
  localparam logic [CW-1:0] CALC_LAST = CW'(CALC_CYCLES - 1);

  state_e            state;
  cfg_fields_t       cfg;
  dp_cfg_t           dp_q;
  logic              finish_q;
  logic              wr_allow;

  logic [BW-1:0]     beat_cnt;
  logic [CW-1:0]     calc_cnt;
  logic [MOVE_W-1:0] x_cnt, y_cnt, z_cnt;
  logic [MOVE_W-1:0] xm_j, ym_j, zm_j;
  logic [WRC_W-1:0]  wr_cnt, wr_j;
  logic              x_last, y_last, z_last;

`ifdef CFG_LOCK_EN
  assign wr_allow = (state == IDLE);
`else
  assign wr_allow = 1'b1;
`endif

  design1_cfg_regs u_cfg (
    .clk    (i_clk),
    .rst    (i_rst),
    .wr_en  (bus.i_cfg_wr_en & wr_allow),
    .addr   (bus.i_cfg_addr),
    .wdata  (bus.i_cfg),
    .fields (cfg)
  );

  assign x_last = (x_cnt == xm_j - MOVE_W'(1));
  assign y_last = (y_cnt == ym_j - MOVE_W'(1));
  assign z_last = (z_cnt == zm_j - MOVE_W'(1));

  assign bus.o_finish = finish_q;
  assign bus.dp_cfg   = dp_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      finish_q <= 1'b0;
      dp_q     <= '0;
      beat_cnt <= '0;
      calc_cnt <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      z_cnt    <= '0;
      xm_j     <= '0;
      ym_j     <= '0;
      zm_j     <= '0;
      wr_cnt   <= '0;
      wr_j     <= '0;
    end else begin
      finish_q <= 1'b0;
      case (state)
        IDLE: begin
          // Snapshot sees the pre-write cfg value on a same-edge write.
          if (bus.i_start) begin
            dp_q     <= cfg.dp;
            xm_j     <= move_norm(cfg.xmove);
            ym_j     <= move_norm(cfg.ymove);
            zm_j     <= move_norm(cfg.zmove);
            wr_j     <= cfg.wr_count;
            x_cnt    <= '0;
            y_cnt    <= '0;
            z_cnt    <= '0;
            beat_cnt <= '0;
            calc_cnt <= '0;
            wr_cnt   <= '0;
            state    <= RD;
          end
        end
        RD: begin
          if (bus.i_dma_rd_ready) begin
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              state    <= CALC;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        CALC: begin
          if (calc_cnt == CALC_LAST) begin
            calc_cnt <= '0;
            if (x_last && y_last && z_last) begin
              wr_cnt <= '0;
              state  <= (wr_j == '0) ? DONE : WR;
            end else begin
              // x innermost, then y, then z
              if (!x_last) begin
                x_cnt <= x_cnt + MOVE_W'(1);
              end else begin
                x_cnt <= '0;
                if (!y_last) begin
                  y_cnt <= y_cnt + MOVE_W'(1);
                end else begin
                  y_cnt <= '0;
                  z_cnt <= z_cnt + MOVE_W'(1);
                end
              end
              state <= RD;
            end
          end else begin
            calc_cnt <= calc_cnt + CW'(1);
          end
        end
        WR: begin
          if (wr_cnt == wr_j - WRC_W'(1)) state  <= DONE;
          else                             wr_cnt <= wr_cnt + WRC_W'(1);
        end
        DONE: begin
          finish_q <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_design1_wrapper.sv
// Directed, table-driven bench for the DRL control shell: finish latency,
// pulse width, ready stalls, ignored restarts, reset abort and cfg write rules.
module tb_design1_wrapper;
  import design1_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  design1_if bus ();

  design1_wrapper dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] w0, w1, w2, w3;
    int          mode;       // 0: ready high, 1: toggling, 2: low for 50 cycles
    bit          mid_start;
    int          exp;
    string       nm;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.i_cfg       = d;
    bus.i_cfg_addr  = a;
    bus.i_cfg_wr_en = 1'b1;
    @(posedge clk);
    #1 bus.i_cfg_wr_en = 1'b0;
  endtask

  task automatic write_all(input logic [15:0] w0, w1, w2, w3);
    write_cfg(CFG_W0, w0);
    write_cfg(CFG_W1, w1);
    write_cfg(CFG_W2, w2);
    write_cfg(CFG_W3, w3);
  endtask

  // Start a job, then count edges past the start-sampling edge. A write of
  // wd to word wa happens at edge wr_edge (0 means same edge as start).
  task automatic run_job(input int mode, input bit mid_start, input int lim,
                         input int wr_edge, input logic [1:0] wa, input logic [15:0] wd,
                         output int fin_edge, output int pulses);
    fin_edge = -1;
    pulses   = 0;
    @(negedge clk);
    bus.i_start        = 1'b1;
    bus.i_dma_rd_ready = 1'b1;
    bus.i_cfg          = wd;
    bus.i_cfg_addr     = wa;
    bus.i_cfg_wr_en    = (wr_edge == 0);
    @(posedge clk);
    #1;
    bus.i_start     = 1'b0;
    bus.i_cfg_wr_en = 1'b0;
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk);
      case (mode)
        1:       bus.i_dma_rd_ready = (n % 2 == 0);
        2:       bus.i_dma_rd_ready = (n > 50);
        default: bus.i_dma_rd_ready = 1'b1;
      endcase
      bus.i_start     = mid_start && (n == 50 || n == 51);
      bus.i_cfg_wr_en = (n == wr_edge);
      @(posedge clk);
      #1;
      if (bus.o_finish) begin
        pulses++;
        if (fin_edge < 0) fin_edge = n;
      end
    end
    bus.i_start     = 1'b0;
    bus.i_cfg_wr_en = 1'b0;
  endtask

  initial begin
    int fe, pc;
    bus.i_cfg          = '0;
    bus.i_cfg_addr     = '0;
    bus.i_cfg_wr_en    = 1'b0;
    bus.i_start        = 1'b0;
    bus.i_dma_rd_ready = 1'b0;

    //          w0       w1       w2       w3       mode mid exp   name
    vecs[0] = '{16'hCE00, 16'h0404, 16'h0003, 16'd200,  0, 0, 345,  "six_tiles"};
    vecs[1] = '{16'hCE00, 16'h0404, 16'h0003, 16'd200,  1, 0, 441,  "ready_toggle"};
    vecs[2] = '{16'h0000, 16'h0204, 16'h0001, 16'd0,    0, 0, 25,   "wr_skipped"};
    vecs[3] = '{16'hCE00, 16'h0404, 16'h0003, 16'd200,  0, 1, 345,  "restart_ignored"};
    vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 16'd0,    0, 0, 25,   "zero_moves"};
    vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 16'd5,    0, 0, 30,   "zero_moves_wr5"};
    vecs[6] = '{16'h1234, 16'h020C, 16'h0002, 16'd1,    0, 0, 146,  "x2_y3_z1_wr1"};
    vecs[7] = '{16'h0000, 16'h0204, 16'h0001, 16'hFFFF, 0, 0, 4120, "max_wr_count"};
    vecs[8] = '{16'h0000, 16'h0204, 16'h0001, 16'd0,    2, 0, 75,   "ready_stall"};

    // Reset state
    do_reset();
    check("rst_finish", int'(bus.o_finish), 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    for (int i = 0; i < 4; i++) check($sformatf("rst_cfg%0d", i), int'(dut.u_cfg.cfg_q[i]), 0);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      write_all(vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3);
      run_job(vecs[v].mode, vecs[v].mid_start, vecs[v].exp + 10, -1, 2'd0, 16'h0, fe, pc);
      check({vecs[v].nm, "_finish_edge"}, fe, vecs[v].exp);
      check({vecs[v].nm, "_pulses"}, pc, 1);
      if (v == 0) begin
        check("dp_mode", int'(bus.dp_cfg.mode), 3);
        check("dp_relu", int'(bus.dp_cfg.relu), 1);
        check("dp_stride", int'(bus.dp_cfg.stride), 6);
      end
    end

    // Reset mid-RD aborts the job and clears cfg
    do_reset();
    write_all(16'hCE00, 16'h0404, 16'h0003, 16'd200);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_dma_rd_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_state", int'(dut.state), int'(IDLE));
    for (int i = 0; i < 4; i++) check($sformatf("abort_cfg%0d", i), int'(dut.u_cfg.cfg_q[i]), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pc = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1 if (bus.o_finish) pc++;
    end
    check("abort_no_finish", pc, 0);

    // Same-edge write and start: job uses old w2 (3 tiles), word takes new value
    do_reset();
    write_all(16'h0000, 16'h0204, 16'h0003, 16'd0);
    run_job(0, 0, 90, 0, CFG_W2, 16'h0001, fe, pc);
    check("same_edge_finish", fe, 73);
    check("same_edge_word", int'(dut.u_cfg.cfg_q[2]), 1);

    // Write w2 during a job
    do_reset();
    write_all(16'h0000, 16'h0204, 16'h0001, 16'd0);
    run_job(0, 0, 40, 5, CFG_W2, 16'h0003, fe, pc);
    check("midjob_wr_finish", fe, 25);
`ifdef CFG_LOCK_EN
    check("midjob_wr_word", int'(dut.u_cfg.cfg_q[2]), 1);
    run_job(0, 0, 90, -1, 2'd0, 16'h0, fe, pc);
    check("midjob_wr_next_job", fe, 25);
`else
    check("midjob_wr_word", int'(dut.u_cfg.cfg_q[2]), 3);
    run_job(0, 0, 90, -1, 2'd0, 16'h0, fe, pc);
    check("midjob_wr_next_job", fe, 73);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
